adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares the single pipelined 32-bit `adder` in the sail-core datapath between two requesters, e.g. the PC-increment and branch-target paths. Each cycle it grants at most one requester with a valid/ready handshake and drives the adder operands. A tag shift register matched to the adder latency routes each result back to the requester that issued it. The block sits between the requesters and the adder instance; it contains no arithmetic of its own.

## Interface
- `LATENCY`, 1: adder pipeline depth in clock edges; legal range 1–8.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req0_valid`, `req1_valid`  in  1: requester has an operand pair.
- `req0_ready`, `req1_ready`  out  1: grant; the transfer occurs when valid and ready are both high at a rising edge.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32: operands.
- `add_in1`, `add_in2`  out  32: operands to the adder `input1`/`input2`.
- `add_out`  in  32: adder `out`, valid `LATENCY` edges after issue.
- `rsp0_valid`, `rsp1_valid`  out  1: result for the requester is present this cycle (single-cycle pulse).
- `rsp_data`  out  32: result data, shared by both responses.
- `busy`  out  1: at least one operation is in flight.

## Operation
- Grant logic is combinational. At most one `reqN_ready` is high, and only if that requester's `reqN_valid` is high. A ready is never raised without its valid.
- Arbitration:
  - Both valid: the winner is chosen by policy (see Configuration).
  - Only one valid: that requester wins.
  - Neither valid: no grant.
- Issue: `add_in1`/`add_in2` carry the granted requester's a/b. With no grant they are driven 0/0.
- Tag pipeline: `LATENCY` stages, each {valid, id}. Stage 0 loads {grant_any, granted_id} at every edge; the other stages shift.
- Response:
  - `rspN_valid` = last-stage valid AND last-stage id == N.
  - `rsp_data` = `add_out` when a response is valid, else 0.
- Responses have no backpressure. Requesters must accept a result in the cycle it is presented.
- Width rule: the sum is taken modulo 2^32; the carry-out is discarded by the adder.
- `busy` = OR of all tag-stage valid bits.
- Throughput: one issue per cycle sustained, with no bubbles between grants.
- Boundary conditions:
  - Both requesters valid on every cycle: grants follow the policy with no idle cycles.
  - A requester may drop valid without being granted; nothing is issued for it.
  - The same requester may have up to `LATENCY` operations in flight. Its results return in issue order.

## Timing
- Reset values: all tag stages invalid; `rsp0_valid` = `rsp1_valid` = 0; `rsp_data` = 0; `busy` = 0; round-robin pointer = requester 0. `reqN_ready` and `add_in*` follow their inputs combinationally.
- Latency: an operation issued at edge k is presented on `rspN_valid`/`rsp_data` in the cycle after edge k+`LATENCY`-1, i.e. `LATENCY` cycles after the issue cycle.
- Reset asserted mid-operation: all in-flight tags are cleared immediately and asynchronously. No response appears for operations issued before reset. Ready signals resume on the first cycle after deassertion.
- The `adder` instance shares `clk`/`rst`. Its `LATENCY` must equal the parameter value; the bench checks this.

## Configuration
- Macro: `ADDER_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - A one-bit pointer names the preferred requester; on contention the preferred requester wins.
  - After any grant, the pointer moves to the other requester.
  - With both requesters valid every cycle, grants alternate 0,1,0,1…
- Undefined: fixed priority. Requester 0 always wins contention. The pointer register is not built.

## Test plan
- Reset, then req0 alone: 0+10, then 1000+10, then 12345+54321 on consecutive cycles. Expect `rsp0_valid` pulses with 10, 1010, 66666 at 1-cycle latency (`LATENCY`=1), and `rsp1_valid` never asserted.
- Both requesters valid for 4 cycles; req0 issues 1+1, req1 issues 2+2. With `ADDER_ARB_RR_EN`: grants 0,1,0,1, responses 2,4,2,4. Without it: grants 0,0,0,0, `req1_ready` stays 0, responses 2,2,2,2.
- Wrap-around: req1 issues 0xFFFFFFFF+1. Expect `rsp1_valid`=1 with `rsp_data`=0x00000000.
- `LATENCY`=3, req0 issues 5+5 and req1 issues 7+7 back-to-back. Expect `busy`=1 for 4 cycles, rsp0=10 at cycle 3, rsp1=14 at cycle 4, in issue order.
- Reset pulse while two operations are in flight (`LATENCY`=3). Expect `busy`=0 and `rsp*_valid`=0 immediately, and no stale responses after deassertion.
- Idle with no valids. Expect `add_in1`=`add_in2`=0, `busy`=0, and no responses.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of a shared pipelined 32-bit adder; a tag pipe routes results back.
// Define ADDER_ARB_RR_EN for round-robin contention; default build is fixed priority (requester 0 wins).
module adder_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  input  logic [31:0] add_out,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic gnt0, gnt1, gnt_any;
  tag_t tag_d, tag_last;
  tag_t [LATENCY-1:0] tag_q;

`ifdef ADDER_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer names the preferred requester; it flips to the other side after every grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = gnt0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

  // No grant while reset is held, so nothing is issued that the cleared tag pipe would lose.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
`ifdef ADDER_ARB_RR_EN
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign gnt_any    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    add_in1 = '0;
    add_in2 = '0;
    if (gnt0) begin
      add_in1 = req0_a;
      add_in2 = req0_b;
    end else if (gnt1) begin
      add_in1 = req1_a;
      add_in2 = req1_b;
    end
  end

  assign tag_d = '{vld: gnt_any, id: gnt1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_last   = tag_q[LATENCY-1];
  assign rsp0_valid = tag_last.vld & ~tag_last.id;
  assign rsp1_valid = tag_last.vld &  tag_last.id;
  assign rsp_data   = tag_last.vld ? add_out : 32'd0;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy = busy | tag_q[i].vld;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: LATENCY=1 and LATENCY=3 instances share stimulus, each with its own adder and model.
module tb_adder_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

  always #5 clk = ~clk;

  logic        r0_1, r1_1, rv0_1, rv1_1, busy_1;
  logic [31:0] in1_1, in2_1, ao_1, rd_1;
  logic        r0_3, r1_3, rv0_3, rv1_3, busy_3;
  logic [31:0] in1_3, in2_3, ao_3, rd_3;

  adder_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_1), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r1_1), .req1_a(req1_a), .req1_b(req1_b),
    .add_in1(in1_1), .add_in2(in2_1), .add_out(ao_1),
    .rsp0_valid(rv0_1), .rsp1_valid(rv1_1), .rsp_data(rd_1), .busy(busy_1));

  adder_arbiter #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_3), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r1_3), .req1_a(req1_a), .req1_b(req1_b),
    .add_in1(in1_3), .add_in2(in2_3), .add_out(ao_3),
    .rsp0_valid(rv0_3), .rsp1_valid(rv1_3), .rsp_data(rd_3), .busy(busy_3));

  // Stand-in adders whose depth equals each instance's LATENCY.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) p1 <= '0;
    else     p1 <= in1_1 + in2_1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p3[0] <= '0; p3[1] <= '0; p3[2] <= '0;
    end else begin
      p3[0] <= in1_3 + in2_3; p3[1] <= p3[0]; p3[2] <= p3[1];
    end
  end
  assign ao_1 = p1;
  assign ao_3 = p3[2];

  // Per-instance views for the model loop.
  logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], bsy [2];
  logic [31:0] ai1 [2], ai2 [2], rd [2];
  assign rdy0[0] = r0_1;  assign rdy0[1] = r0_3;
  assign rdy1[0] = r1_1;  assign rdy1[1] = r1_3;
  assign rv0[0]  = rv0_1; assign rv0[1]  = rv0_3;
  assign rv1[0]  = rv1_1; assign rv1[1]  = rv1_3;
  assign bsy[0]  = busy_1; assign bsy[1] = busy_3;
  assign ai1[0]  = in1_1; assign ai1[1]  = in1_3;
  assign ai2[0]  = in2_1; assign ai2[1]  = in2_3;
  assign rd[0]   = rd_1;  assign rd[1]   = rd_3;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // Model: a response calendar indexed by negedge number; an issue seen at negedge n lands at n+LATENCY.
  int          lat [2] = '{1, 3};
  bit          sv  [2][64];
  bit          sid [2][64];
  logic [31:0] sd  [2][64];
  bit          pref [2];
  int          n = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int s, g;
      bit eb;
      logic [31:0] ea1, ea2;
      s = n % 64;
      if (rst) begin
        chk($sformatf("rst_rsp0[%0d]", d), {31'd0, rv0[d]}, 32'd0);
        chk($sformatf("rst_rsp1[%0d]", d), {31'd0, rv1[d]}, 32'd0);
        chk($sformatf("rst_data[%0d]", d), rd[d], 32'd0);
        chk($sformatf("rst_busy[%0d]", d), {31'd0, bsy[d]}, 32'd0);
        chk($sformatf("rst_rdy[%0d]", d), {30'd0, rdy1[d], rdy0[d]}, 32'd0);
        for (int k = 0; k < 64; k++) sv[d][k] = 1'b0;
        pref[d] = 1'b0;
      end else begin
        eb = 1'b0;
        for (int k = 0; k < lat[d]; k++) eb = eb | sv[d][(n + k) % 64];
        chk($sformatf("busy[%0d]", d), {31'd0, bsy[d]}, {31'd0, eb});
        chk($sformatf("rsp0[%0d]", d), {31'd0, rv0[d]}, {31'd0, sv[d][s] && !sid[d][s]});
        chk($sformatf("rsp1[%0d]", d), {31'd0, rv1[d]}, {31'd0, sv[d][s] && sid[d][s]});
        chk($sformatf("data[%0d]", d), rd[d], sv[d][s] ? sd[d][s] : 32'd0);
        sv[d][s] = 1'b0;
        g = -1;
        if (req0_valid && req1_valid) begin
`ifdef ADDER_ARB_RR_EN
          g = pref[d] ? 1 : 0;
`else
          g = 0;
`endif
        end else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        ea1 = (g == 0) ? req0_a : (g == 1) ? req1_a : 32'd0;
        ea2 = (g == 0) ? req0_b : (g == 1) ? req1_b : 32'd0;
        chk($sformatf("rdy0[%0d]", d), {31'd0, rdy0[d]}, {31'd0, g == 0});
        chk($sformatf("rdy1[%0d]", d), {31'd0, rdy1[d]}, {31'd0, g == 1});
        chk($sformatf("in1[%0d]", d), ai1[d], ea1);
        chk($sformatf("in2[%0d]", d), ai2[d], ea2);
        if (g >= 0) begin
          sv[d][(n + lat[d]) % 64]  = 1'b1;
          sid[d][(n + lat[d]) % 64] = (g == 1);
          sd[d][(n + lat[d]) % 64]  = ea1 + ea2;
          pref[d] = (g == 0);
        end
      end
    end
    n++;
  end

  task automatic drive(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                       input bit v1, input logic [31:0] a1, input logic [31:0] b1);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstnow_busy3", {31'd0, busy_3}, 32'd0);
    chk("rstnow_rsp3", {30'd0, rv1_3, rv0_3}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [31:0] ra [4];
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    idle();
    chk("idle_in1", in1_1, 32'd0);
    chk("idle_in2", in2_1, 32'd0);
    chk("idle_busy", {31'd0, busy_1}, 32'd0);

    drive(1'b1, 32'd0, 32'd10, 1'b0, 32'd0, 32'd0);
    chk("solo_rdy0", {31'd0, r0_1}, 32'd1);
    drive(1'b1, 32'd1000, 32'd10, 1'b0, 32'd0, 32'd0);
    chk("solo_r1", rd_1, 32'd10);
    chk("solo_v1", {31'd0, rv0_1}, 32'd1);
    drive(1'b1, 32'd12345, 32'd54321, 1'b0, 32'd0, 32'd0);
    chk("solo_r2", rd_1, 32'd1010);
    idle();
    chk("solo_r3", rd_1, 32'd66666);
    chk("solo_no_rsp1", {31'd0, rv1_1}, 32'd0);
    repeat (3) idle();

    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd1, 32'd1, 1'b1, 32'd2, 32'd2);
`ifdef ADDER_ARB_RR_EN
      chk($sformatf("cont_rdy0_%0d", i), {31'd0, r0_1}, {31'd0, (i % 2) == 0});
      if (i > 0) chk($sformatf("cont_rsp_%0d", i - 1), rd_1, ((i - 1) % 2 == 0) ? 32'd2 : 32'd4);
`else
      chk($sformatf("cont_rdy1_%0d", i), {31'd0, r1_1}, 32'd0);
      if (i > 0) chk($sformatf("cont_rsp_%0d", i - 1), rd_1, 32'd2);
`endif
    end
    idle();
`ifdef ADDER_ARB_RR_EN
    chk("cont_rsp_3", rd_1, 32'd4);
`else
    chk("cont_rsp_3", rd_1, 32'd2);
`endif
    repeat (3) idle();

    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    idle();
    chk("wrap_v", {31'd0, rv1_1}, 32'd1);
    chk("wrap_d", rd_1, 32'd0);
    repeat (3) idle();

    pulse_reset();
    drive(1'b1, 32'd5, 32'd5, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 32'd7);
    chk("l3_busy1", {31'd0, busy_3}, 32'd1);
    idle();
    chk("l3_busy2", {31'd0, busy_3}, 32'd1);
    idle();
    chk("l3_rsp0", {31'd0, rv0_3}, 32'd1);
    chk("l3_d0", rd_3, 32'd10);
    idle();
    chk("l3_rsp1", {31'd0, rv1_3}, 32'd1);
    chk("l3_d1", rd_3, 32'd14);
    chk("l3_busy4", {31'd0, busy_3}, 32'd1);
    idle();
    chk("l3_busy5", {31'd0, busy_3}, 32'd0);

    drive(1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd8, 32'd9);
    pulse_reset();
    repeat (6) idle();

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      drive($urandom_range(0, 9) < 6, ra[0], ra[1], $urandom_range(0, 9) < 6, ra[2], ra[3]);
    end
    repeat (6) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
